pcs_tx_os_ctrl_p: RTL and testbench
===================================

// Module: pcs_tx_os_ctrl_p
// PURPOSE
// - 1000BASE-X PCS transmit ordered-set controller, parametrised generation.
// - Decides per code-group slot which ordered set the encoder emits: /I/ /S/ /D/ /T/ /R/ /V/.
// - Adds the following to the basic I-S-D-T-R sequencer:
//   - even/odd alignment with EPD3;
//   - error propagation (/V/);
//   - optional carrier extension;
//   - minimum-IPG enforcement.
// - Sits between the GMII-side TX_EN/TX_ER inputs and the 8b/10b code-group encoder.
// PARAMETERS
// - MIN_IPG  12  min consecutive /I/ slots after EPD before a new /S/ is allowed; 0 = no check
// - EXT_EN   1   1 = carrier extension (TX_ER high with TX_EN low after /T/) emits /R/; 0 = TX_ER ignored after /T/
// PORTS
// - clk            in   1  code-group clock; one code group per cycle
// - mr_main_reset  in   1  asynchronous, active-low reset
// - TX_EN          in   1  GMII transmit enable
// - TX_ER          in   1  GMII transmit error / carrier-extend request
// - tx_o_set       out  6  one-hot ordered set: [0]=I [1]=S [2]=D [3]=T [4]=R [5]=V
// - tx_even        out  1  1 = current code-group slot is even
// - tx_busy        out  1  1 when state != IDLE
// - frame_drop     out  1  one-cycle pulse: frame refused because IPG not satisfied
// BEHAVIOUR
// - Reset (async, mr_main_reset=0):
//   - state=IDLE, tx_o_set=6'b000001, tx_even=1, tx_busy=0, frame_drop=0;
//   - ipg_cnt=MIN_IPG (IPG satisfied), drop flag=0.
// - All outputs registered; tx_o_set is Moore on state; tx_even toggles every cycle after reset.
// - ipg_cnt:
//   - width $clog2(MIN_IPG+1), minimum 1 bit;
//   - cleared on any transition into IDLE; +1 per IDLE cycle, saturates at MIN_IPG;
//   - ipg_ok = (ipg_cnt >= MIN_IPG).
// - State transitions (inputs sampled at clk edge, new set visible next cycle):
//   - IDLE(I):
//     - TX_EN=1 & ipg_ok & tx_even=0 & !drop -> SOP (/S/ lands on an even slot);
//     - TX_EN=1 & ipg_ok & tx_even=1 -> stay IDLE one slot, then SOP (latency 1-2 cycles);
//     - TX_EN=1 & !ipg_ok & !drop -> frame_drop=1 for 1 cycle, drop=1, stay IDLE;
//     - drop=1 holds IDLE until TX_EN=0, then drop clears.
//   - SOP(S): TX_EN=0 -> EOP; TX_EN=1 & TX_ER=1 -> ERR; else -> DATA.
//   - DATA(D) and ERR(V): identical exits:
//     - TX_EN=0 -> EOP;
//     - TX_EN=1 & TX_ER=1 -> ERR;
//     - TX_EN=1 & TX_ER=0 -> DATA.
//   - EOP(T): unconditionally -> EPD2.
//   - EPD2(R):
//     - EXT_EN=1 & TX_EN=0 & TX_ER=1 -> EXT;
//     - else tx_even=1 -> EPD3;
//     - else -> IDLE.
//   - EXT(R): while TX_ER=1 & TX_EN=0 stay EXT. On exit (includes TX_EN=1, which is ignored):
//     - tx_even=1 -> EPD3;
//     - else -> IDLE.
//   - EPD3(R): unconditionally -> IDLE.
// - Invariant: first /I/ after any frame is on an even slot.
// - Invariant: /S/ always on an even slot.
// - TX_EN rising during EOP/EPD2/EPD3/EXT: not accepted. The frame is handled in IDLE under the IPG rule.
// - Simultaneous TX_EN=1 & TX_ER=1 in IDLE: treated as TX_EN=1 (normal SOP; /V/ follows on the next slot).
// - Illegal/unused state encoding: -> IDLE next cycle with tx_o_set=I.
// - Reset mid-frame: immediate IDLE/I output, tx_even=1, IPG considered satisfied.
// TESTING
// - Reset check: hold mr_main_reset=0 then release.
//   -> tx_o_set=000001, tx_even=1, tx_busy=0, frame_drop=0.
// - Basic frame: TX_EN raised on an odd slot, held so 3 /D/ are sent.
//   -> I,S(e),D,D,D,T(e),R(o),I(e); no EPD3.
// - Alignment: same stimulus with 4 /D/.
//   -> S,D,D,D,D,T(o),R(e),R(o),I(e); EPD3 inserted.
// - Error propagation: TX_ER=1 for 2 cycles mid-frame with TX_EN=1.
//   -> ...D,V,V,D...; frame ends normally with T,R.
// - Carrier extension: EXT_EN=1; after TX_EN falls, TX_ER=1 for 5 cycles.
//   -> T,R,R,R,R,R(,R if even),I; tx_busy=1 throughout.
// - IPG with MIN_IPG=4: TX_EN re-raised 2 cycles after first /I/.
//   -> frame_drop pulse once, output stays I until TX_EN low.
//   -> next TX_EN after 4 /I/ is accepted.

Source files
------------

// File: rtl/pcs_tx_os_ctrl_p_if.sv
// GMII-side transmit controls and ordered-set selection outputs of the PCS TX controller.
interface pcs_tx_os_ctrl_p_if;
  logic       TX_EN;
  logic       TX_ER;
  logic [5:0] tx_o_set;
  logic       tx_even;
  logic       tx_busy;
  logic       frame_drop;

  modport master (
    output TX_EN,
    output TX_ER,
    input  tx_o_set,
    input  tx_even,
    input  tx_busy,
    input  frame_drop
  );

  modport slave (
    input  TX_EN,
    input  TX_ER,
    output tx_o_set,
    output tx_even,
    output tx_busy,
    output frame_drop
  );
endinterface

// File: rtl/pcs_tx_os_ctrl_p.sv
// 1000BASE-X PCS transmit ordered-set controller: chooses /I/ /S/ /D/ /T/ /R/ /V/ per slot
// with even-slot alignment, error propagation, carrier extension and minimum-IPG enforcement.
module pcs_tx_os_ctrl_p #(
  parameter int unsigned MIN_IPG = 12,
  parameter bit          EXT_EN  = 1'b1
) (
  input logic                clk,
  input logic                mr_main_reset,
  pcs_tx_os_ctrl_p_if.slave  tx_if
);

  localparam int unsigned CntW = (MIN_IPG > 0) ? $clog2(MIN_IPG + 1) : 1;
  localparam logic [CntW-1:0] IpgMax = CntW'(MIN_IPG);

  typedef enum logic [2:0] {
    StIdle, StSop, StData, StErr, StEop, StEpd2, StExt, StEpd3
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] ipg_cnt_q, ipg_cnt_d;
  logic            drop_q, drop_d;
  logic            fd_d;
  logic            even_q;
  logic [5:0]      o_set_q;
  logic            busy_q;
  logic            fd_q;
  logic            ipg_ok;

  function automatic logic [5:0] set_of(state_e s);
    logic [5:0] r;
    r = 6'b000001;
    case (s)
      StIdle:                  r = 6'b000001;
      StSop:                   r = 6'b000010;
      StData:                  r = 6'b000100;
      StEop:                   r = 6'b001000;
      StEpd2, StExt, StEpd3:   r = 6'b010000;
      StErr:                   r = 6'b100000;
      default:                 r = 6'b000001;
    endcase
    return r;
  endfunction

  assign ipg_ok = (ipg_cnt_q >= IpgMax);

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    fd_d    = 1'b0;
    case (state_q)
      StIdle: begin
        // A refused frame keeps us idle until TX_EN drops, even once the IPG is met.
        if (drop_q) begin
          if (!tx_if.TX_EN) drop_d = 1'b0;
        end else if (tx_if.TX_EN) begin
          if (!ipg_ok) begin
            fd_d   = 1'b1;
            drop_d = 1'b1;
          end else if (!even_q) begin
            state_d = StSop;
          end
        end
      end
      StSop, StData, StErr: begin
        if (!tx_if.TX_EN)     state_d = StEop;
        else if (tx_if.TX_ER) state_d = StErr;
        else                  state_d = StData;
      end
      StEop:  state_d = StEpd2;
      StEpd2: begin
        if (EXT_EN && !tx_if.TX_EN && tx_if.TX_ER) state_d = StExt;
        else if (even_q)                           state_d = StEpd3;
        else                                       state_d = StIdle;
      end
      StExt: begin
        if (tx_if.TX_ER && !tx_if.TX_EN) state_d = StExt;
        else if (even_q)                 state_d = StEpd3;
        else                             state_d = StIdle;
      end
      StEpd3:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ipg_cnt_d = ipg_cnt_q;
    if (state_d == StIdle && state_q != StIdle) begin
      ipg_cnt_d = '0;
    end else if (state_q == StIdle && ipg_cnt_q < IpgMax) begin
      ipg_cnt_d = ipg_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state_q   <= StIdle;
      ipg_cnt_q <= IpgMax;
      drop_q    <= 1'b0;
      even_q    <= 1'b1;
      o_set_q   <= 6'b000001;
      busy_q    <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ipg_cnt_q <= ipg_cnt_d;
      drop_q    <= drop_d;
      even_q    <= ~even_q;
      o_set_q   <= set_of(state_d);
      busy_q    <= (state_d != StIdle);
      fd_q      <= fd_d;
    end
  end

  assign tx_if.tx_o_set   = o_set_q;
  assign tx_if.tx_even    = even_q;
  assign tx_if.tx_busy    = busy_q;
  assign tx_if.frame_drop = fd_q;

endmodule

// File: tb/tb_pcs_tx_os_ctrl_p.sv
// Directed bench for pcs_tx_os_ctrl_p: per-slot ordered set, parity, busy and drop pulse.
module tb_pcs_tx_os_ctrl_p;

  logic clk = 1'b0;
  logic mr_main_reset = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  pcs_tx_os_ctrl_p_if dut_if ();

  pcs_tx_os_ctrl_p #(
    .MIN_IPG (4),
    .EXT_EN  (1'b1)
  ) dut (
    .clk           (clk),
    .mr_main_reset (mr_main_reset),
    .tx_if         (dut_if)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] char_set(byte c);
    logic [5:0] r;
    case (c)
      "I":     r = 6'b000001;
      "S":     r = 6'b000010;
      "D":     r = 6'b000100;
      "T":     r = 6'b001000;
      "R":     r = 6'b010000;
      "V":     r = 6'b100000;
      default: r = 6'b000000;
    endcase
    return r;
  endfunction

  // {set, even, busy, frame_drop}; slot 0 is the even reset slot.
  function automatic logic [8:0] make_exp(byte c, int j, bit fd);
    return {char_set(c), (j % 2) == 0, c != "I", fd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    mr_main_reset = 1'b0;
    dut_if.TX_EN  = 1'b0;
    dut_if.TX_ER  = 1'b0;
    repeat (2) @(negedge clk);
    mr_main_reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    dut_if.TX_EN  = 1'b0;
    dut_if.TX_ER  = 1'b0;
    mr_main_reset = 1'b0;
    #1;
    n_cmp++;
    if (dut_if.tx_o_set !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_set: got %b want 000001", dut_if.tx_o_set);
    end
    n_cmp++;
    if (dut_if.tx_even !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_even: got %b want 1", dut_if.tx_even);
    end
    n_cmp++;
    if (dut_if.tx_busy !== 1'b0 || dut_if.frame_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy_drop: got %b%b want 00", dut_if.tx_busy, dut_if.frame_drop);
    end
    @(negedge clk);
    mr_main_reset = 1'b1;
    tick();
    obs = {dut_if.tx_o_set, dut_if.tx_even, dut_if.tx_busy, dut_if.frame_drop};
    n_cmp++;
    if (obs !== 9'b000001_0_0_0) begin
      n_fail++;
      $display("FAIL reset_first_edge: got %b want 000001000", obs);
    end
  endtask

  task automatic test_basic_frame();
    string exp_s, en_s;
    logic [8:0] obs, exp_v;
    exp_s = "IISDDDTRI";
    en_s  = "011110000";
    apply_reset();
    for (int j = 0; j < exp_s.len(); j++) begin
      exp_v = make_exp(exp_s[j], j, 1'b0);
      obs = {dut_if.tx_o_set, dut_if.tx_even, dut_if.tx_busy, dut_if.frame_drop};
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL basic slot %0d: got %b want %b", j, obs, exp_v);
      end
      dut_if.TX_EN = (en_s[j] == "1");
      dut_if.TX_ER = 1'b0;
      tick();
    end
  endtask

  task automatic test_alignment();
    string exp_s, en_s;
    logic [8:0] obs, exp_v;
    exp_s = "IISDDDDTRRI";
    en_s  = "01111100000";
    apply_reset();
    for (int j = 0; j < exp_s.len(); j++) begin
      exp_v = make_exp(exp_s[j], j, 1'b0);
      obs = {dut_if.tx_o_set, dut_if.tx_even, dut_if.tx_busy, dut_if.frame_drop};
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL align slot %0d: got %b want %b", j, obs, exp_v);
      end
      dut_if.TX_EN = (en_s[j] == "1");
      dut_if.TX_ER = 1'b0;
      tick();
    end
  endtask

  // TX_ER alongside the opening TX_EN is ignored in idle; two TX_ER slots mid-frame give /V/ /V/.
  task automatic test_error_prop();
    string exp_s, en_s, er_s;
    logic [8:0] obs, exp_v;
    exp_s = "IISDVVDDTRI";
    en_s  = "01111110000";
    er_s  = "01011000000";
    apply_reset();
    for (int j = 0; j < exp_s.len(); j++) begin
      exp_v = make_exp(exp_s[j], j, 1'b0);
      obs = {dut_if.tx_o_set, dut_if.tx_even, dut_if.tx_busy, dut_if.frame_drop};
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL errprop slot %0d: got %b want %b", j, obs, exp_v);
      end
      dut_if.TX_EN = (en_s[j] == "1");
      dut_if.TX_ER = (er_s[j] == "1");
      tick();
    end
  endtask

  task automatic test_carrier_ext();
    string exp_s, en_s, er_s;
    logic [8:0] obs, exp_v;
    exp_s = "IISDTRRRRRI";
    en_s  = "01100000000";
    er_s  = "00011111000";
    apply_reset();
    for (int j = 0; j < exp_s.len(); j++) begin
      exp_v = make_exp(exp_s[j], j, 1'b0);
      obs = {dut_if.tx_o_set, dut_if.tx_even, dut_if.tx_busy, dut_if.frame_drop};
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL carrext slot %0d: got %b want %b", j, obs, exp_v);
      end
      dut_if.TX_EN = (en_s[j] == "1");
      dut_if.TX_ER = (er_s[j] == "1");
      tick();
    end
  endtask

  // MIN_IPG=4: early re-request is dropped once and held off until TX_EN falls; a later request
  // on an even slot waits one slot so /S/ stays even.
  task automatic test_ipg();
    string exp_s, en_s;
    logic [8:0] obs, exp_v;
    exp_s = "IISDDDTRIIIIIIIISDTRI";
    en_s  = "011110000111101110000";
    apply_reset();
    for (int j = 0; j < exp_s.len(); j++) begin
      exp_v = make_exp(exp_s[j], j, j == 10);
      obs = {dut_if.tx_o_set, dut_if.tx_even, dut_if.tx_busy, dut_if.frame_drop};
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL ipg slot %0d: got %b want %b", j, obs, exp_v);
      end
      dut_if.TX_EN = (en_s[j] == "1");
      dut_if.TX_ER = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [8:0] obs;
    apply_reset();
    tick();
    dut_if.TX_EN = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (dut_if.tx_o_set !== 6'b000100) begin
      n_fail++;
      $display("FAIL midrst_pre: got %b want 000100", dut_if.tx_o_set);
    end
    #1;
    mr_main_reset = 1'b0;
    dut_if.TX_EN  = 1'b0;
    #1;
    obs = {dut_if.tx_o_set, dut_if.tx_even, dut_if.tx_busy, dut_if.frame_drop};
    n_cmp++;
    if (obs !== 9'b000001_1_0_0) begin
      n_fail++;
      $display("FAIL midrst_async: got %b want 000001100", obs);
    end
    @(negedge clk);
    mr_main_reset = 1'b1;
    tick();
    dut_if.TX_EN = 1'b1;
    tick();
    obs = {dut_if.tx_o_set, dut_if.tx_even, dut_if.tx_busy, dut_if.frame_drop};
    n_cmp++;
    if (obs !== 9'b000010_1_1_0) begin
      n_fail++;
      $display("FAIL midrst_ipg_ok: got %b want 000010110", obs);
    end
    dut_if.TX_EN = 1'b0;
    tick();
    n_cmp++;
    if (dut_if.tx_o_set !== 6'b001000) begin
      n_fail++;
      $display("FAIL midrst_eop: got %b want 001000", dut_if.tx_o_set);
    end
  endtask

  initial begin
    dut_if.TX_EN = 1'b0;
    dut_if.TX_ER = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic_frame();
    test_alignment();
    test_error_prop();
    test_carrier_ext();
    test_ipg();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
